// File: rtl/rv32v_rf_elem_sequencer.sv
// rtl/rv32v_rf_elem_sequencer.sv - vector register file read-port element sequencer

package rv32i_types_pkg;
  // vl is VL_WIDTH+1 bits so the full-scale element count fits.
  localparam int VL_WIDTH = 5;
  // Element index into a vector register group.
  typedef logic [VL_WIDTH:0] offset_t;
endpackage

module rv32v_rf_elem_sequencer
  import rv32i_types_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  start,
  output logic                  ready,
  input  logic [VL_WIDTH:0]     vl_in,
  input  logic [4:0]            vs1_in,
  input  logic [4:0]            vs2_in,
  input  logic [4:0]            vs3_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic [4:0]            vs1,
  output logic [4:0]            vs2,
  output logic [4:0]            vs3,
  output offset_t [LANES-1:0]   vs1_offset,
  output offset_t [LANES-1:0]   vs2_offset,
  output offset_t [LANES-1:0]   vs3_offset,
  output logic [LANES-1:0]      lane_valid,
  output logic                  beat_valid,
  output logic                  last,
  output logic                  done
);

  // One bit wider than vl so base + LANES never wraps.
  localparam int BW = VL_WIDTH + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  state_t            next_state;
  logic [BW-1:0]     base;
  logic [VL_WIDTH:0] vl_q;
  logic              running;
  logic              last_hit;
  logic              accept;
  logic              start_ok;

  assign running  = (state == RUN);
  assign last_hit = ((base + BW'(LANES)) >= BW'(vl_q));
  assign accept   = running & ~stall;
  // flush drops a start issued in the same cycle.
  assign start_ok = (state == IDLE) & start & ~flush;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: flush wins over any accept, a zero-length start never leaves IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok && (vl_in != '0)) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          next_state = IDLE;
        end else if (accept && last_hit) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latches, element base and the registered done pulse.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vs1  <= '0;
      vs2  <= '0;
      vs3  <= '0;
      vl_q <= '0;
      base <= '0;
      done <= 1'b0;
    end else begin
      if (start_ok) begin
        vs1  <= vs1_in;
        vs2  <= vs2_in;
        vs3  <= vs3_in;
        vl_q <= vl_in;
        base <= '0;
      end else if (accept && !last_hit && !flush) begin
        base <= base + BW'(LANES);
      end
      done <= (start_ok && (vl_in == '0)) ||
              (accept && last_hit && !flush);
    end
  end

  // Beat outputs; everything but the register selects is quiet outside RUN.
  always_comb begin
    ready      = (state == IDLE);
    beat_valid = running;
    last       = running & last_hit;
    vs1_offset = '0;
    vs2_offset = '0;
    vs3_offset = '0;
    lane_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      if (running) begin
        vs1_offset[i] = offset_t'(base + BW'(i));
        vs2_offset[i] = offset_t'(base + BW'(i));
        vs3_offset[i] = offset_t'(base + BW'(i));
        lane_valid[i] = ((base + BW'(i)) < BW'(vl_q));
      end
    end
  end

endmodule

// File: tb/tb_rv32v_rf_elem_sequencer.sv
// tb/tb_rv32v_rf_elem_sequencer.sv - self-checking bench for the element sequencer

module tb_rv32v_rf_elem_sequencer;
  import rv32i_types_pkg::*;

  localparam int L = 2;
  localparam int VLMAX = (1 << (VL_WIDTH + 1)) - 1;

  logic                CLK;
  logic                nRST;
  logic                start;
  logic                ready;
  logic [VL_WIDTH:0]   vl_in;
  logic [4:0]          vs1_in, vs2_in, vs3_in;
  logic                stall;
  logic                flush;
  logic [4:0]          vs1, vs2, vs3;
  offset_t [L-1:0]     vs1_offset, vs2_offset, vs3_offset;
  logic [L-1:0]        lane_valid;
  logic                beat_valid;
  logic                last;
  logic                done;

  int checks = 0;
  int errors = 0;

  rv32v_rf_elem_sequencer #(.LANES(L)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .ready(ready), .vl_in(vl_in),
    .vs1_in(vs1_in), .vs2_in(vs2_in), .vs3_in(vs3_in), .stall(stall), .flush(flush),
    .vs1(vs1), .vs2(vs2), .vs3(vs3),
    .vs1_offset(vs1_offset), .vs2_offset(vs2_offset), .vs3_offset(vs3_offset),
    .lane_valid(lane_valid), .beat_valid(beat_valid), .last(last), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Checks that the sequencer is quiet: no beat, given ready/done, zero offsets and mask.
  task automatic check_quiet(input string name, input logic exp_ready, input logic exp_done);
    checks++;
    if ({beat_valid, last, ready, done, lane_valid} !== {1'b0, 1'b0, exp_ready, exp_done, {L{1'b0}}}) begin
      errors++;
      $display("FAIL %s_ctrl: got bv=%b last=%b ready=%b done=%b lv=%b, expected bv=0 last=0 ready=%b done=%b lv=0",
               name, beat_valid, last, ready, done, lane_valid, exp_ready, exp_done);
    end
    checks++;
    if ({vs1_offset, vs2_offset, vs3_offset} !== '0) begin
      errors++;
      $display("FAIL %s_offsets: got %h %h %h, expected 0", name, vs1_offset, vs2_offset, vs3_offset);
    end
  endtask

  // Drives one operation and checks every beat against a beat-index model.
  // Caller is 1 time unit past a rising edge with the sequencer ready.
  task automatic run_op(input string name, input int vl, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] r3, input int stall_pct, input int stall_beat,
                        input int stall_len, input bit poke);
    int nbeats, k, edges, stalls, sc;
    bit st;
    offset_t [L-1:0] exp_off;
    logic [L-1:0] exp_lv;
    nbeats = (vl + L - 1) / L;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before_start: got %b expected 1", name, ready);
    end
    start = 1'b1; vl_in = (VL_WIDTH+1)'(vl); vs1_in = r1; vs2_in = r2; vs3_in = r3;
    tick();
    start = 1'b0; vl_in = '0; vs1_in = '0; vs2_in = '0; vs3_in = '0;
    edges = 1; k = 0; stalls = 0; sc = 0;
    while (k < nbeats && edges < 2000) begin
      for (int i = 0; i < L; i++) begin
        exp_off[i] = offset_t'(k * L + i);
        exp_lv[i]  = ((k * L + i) < vl);
      end
      checks++;
      if ({beat_valid, ready, done} !== 3'b100) begin
        errors++;
        $display("FAIL %s_beat%0d_ctrl: got bv/ready/done=%b expected 100", name, k, {beat_valid, ready, done});
      end
      checks++;
      if ({vs1, vs2, vs3} !== {r1, r2, r3}) begin
        errors++;
        $display("FAIL %s_beat%0d_regs: got %0d/%0d/%0d expected %0d/%0d/%0d", name, k, vs1, vs2, vs3, r1, r2, r3);
      end
      checks++;
      if (vs1_offset !== exp_off || vs2_offset !== exp_off || vs3_offset !== exp_off) begin
        errors++;
        $display("FAIL %s_beat%0d_offsets: got %h %h %h expected %h", name, k, vs1_offset, vs2_offset, vs3_offset, exp_off);
      end
      checks++;
      if ({lane_valid, last} !== {exp_lv, (k == nbeats - 1)}) begin
        errors++;
        $display("FAIL %s_beat%0d_mask_last: got lv=%b last=%b expected lv=%b last=%b",
                 name, k, lane_valid, last, exp_lv, (k == nbeats - 1));
      end
      st = ((k == stall_beat) && (sc < stall_len)) || (int'($urandom % 100) < stall_pct);
      stall = st;
      if (poke && k == 0 && edges == 1) begin
        start = 1'b1; vl_in = (VL_WIDTH+1)'(2); vs1_in = ~r1; vs2_in = ~r2; vs3_in = ~r3;
      end
      tick();
      start = 1'b0; stall = 1'b0; vl_in = '0; vs1_in = '0; vs2_in = '0; vs3_in = '0;
      edges++;
      if (st) begin
        stalls++;
        sc++;
      end else begin
        k++;
        sc = 0;
      end
    end
    if (edges >= 2000) begin
      errors++;
      $display("FAIL %s_timeout: got %0d of %0d beats", name, k, nbeats);
    end
    checks++;
    if ({beat_valid, ready, done} !== 3'b011) begin
      errors++;
      $display("FAIL %s_done: got bv/ready/done=%b expected 011", name, {beat_valid, ready, done});
    end
    checks++;
    if (edges !== nbeats + stalls + 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, edges, nbeats + stalls + 1);
    end
    checks++;
    if ({vs1, vs2, vs3} !== {r1, r2, r3}) begin
      errors++;
      $display("FAIL %s_regs_idle: got %0d/%0d/%0d expected %0d/%0d/%0d", name, vs1, vs2, vs3, r1, r2, r3);
    end
  endtask

  task automatic test_reset();
    #2;
    check_quiet("reset_async", 1'b1, 1'b0);
    checks++;
    if ({vs1, vs2, vs3} !== 15'd0) begin
      errors++;
      $display("FAIL reset_regs: got %h expected 0", {vs1, vs2, vs3});
    end
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    check_quiet("reset_release", 1'b1, 1'b0);
  endtask

  task automatic test_basic();
    run_op("basic", 5, 5'd3, 5'd7, 5'd9, 0, -1, 0, 1'b0);
    tick();
    check_quiet("basic_after", 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    run_op("stall", 5, 5'd3, 5'd7, 5'd9, 0, 1, 2, 1'b0);
    tick();
  endtask

  task automatic test_vl_zero();
    run_op("vl0", 0, 5'd1, 5'd2, 5'd4, 0, -1, 0, 1'b0);
    tick();
    check_quiet("vl0_after", 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    start = 1'b1; vl_in = 6'd8; vs1_in = 5'd4; vs2_in = 5'd5; vs3_in = 5'd6;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_quiet("flush_mid", 1'b1, 1'b0);
    tick();
    check_quiet("flush_mid_nodone", 1'b1, 1'b0);
    run_op("after_flush", 1, 5'd10, 5'd11, 5'd12, 0, -1, 0, 1'b0);
    tick();
    // flush on the last beat suppresses done
    start = 1'b1; vl_in = 6'd2; vs1_in = 5'd13; vs2_in = 5'd14; vs3_in = 5'd15;
    tick();
    start = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_quiet("flush_last", 1'b1, 1'b0);
    // flush with start in IDLE drops the start
    start = 1'b1; flush = 1'b1; vl_in = 6'd3; vs1_in = 5'd31; vs2_in = 5'd30; vs3_in = 5'd29;
    tick();
    start = 1'b0; flush = 1'b0;
    check_quiet("flush_start", 1'b1, 1'b0);
    checks++;
    if ({vs1, vs2, vs3} !== {5'd13, 5'd14, 5'd15}) begin
      errors++;
      $display("FAIL flush_start_regs: got %0d/%0d/%0d expected 13/14/15", vs1, vs2, vs3);
    end
    tick();
    check_quiet("flush_start_later", 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("ignore_start", 6, 5'd17, 5'd18, 5'd19, 0, -1, 0, 1'b1);
    run_op("b2b_a", 3, 5'd20, 5'd21, 5'd22, 0, -1, 0, 1'b0);
    run_op("b2b_b", 0, 5'd23, 5'd24, 5'd25, 0, -1, 0, 1'b0);
    run_op("b2b_c", 4, 5'd26, 5'd27, 5'd28, 0, -1, 0, 1'b0);
    tick();
  endtask

  task automatic test_full_scale();
    run_op("full_scale", VLMAX, 5'd31, 5'd0, 5'd16, 0, -1, 0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_op("random", int'($urandom_range(0, VLMAX)), 5'($urandom), 5'($urandom), 5'($urandom),
             25, -1, 0, 1'b0);
      if ($urandom % 2 == 0) tick();
    end
    tick();
  endtask

  task automatic test_async_reset();
    start = 1'b1; vl_in = 6'd8; vs1_in = 5'd9; vs2_in = 5'd8; vs3_in = 5'd7;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (beat_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got bv=%b expected 1", beat_valid);
    end
    #2;
    nRST = 1'b0;
    #1;
    check_quiet("areset_now", 1'b1, 1'b0);
    checks++;
    if ({vs1, vs2, vs3} !== 15'd0) begin
      errors++;
      $display("FAIL areset_regs: got %h expected 0", {vs1, vs2, vs3});
    end
    tick();
    check_quiet("areset_held", 1'b1, 1'b0);
    nRST = 1'b1;
    tick();
    run_op("after_reset", 7, 5'd2, 5'd4, 5'd6, 0, -1, 0, 1'b0);
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; vl_in = '0; vs1_in = '0; vs2_in = '0; vs3_in = '0;
    stall = 1'b0; flush = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_vl_zero();
    test_flush();
    test_back_to_back();
    test_full_scale();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32v_rf_elem_sequencer.md
# rv32v_rf_elem_sequencer

Element sequencer for the vector register file read ports. It latches a vector operation's source registers and active vector length, then walks element offsets `LANES` at a time. Each beat drives the register file's `vs1/vs2/vs3` selects and per-lane offsets, together with a lane-valid mask. It sits between vector decode/issue and the register file `decode` read modport, and honours downstream backpressure.

## Interface
- `LANES`, 2: elements issued per beat; must be a power of two, at least 1.
- Package types from `rv32i_types_pkg`:
  - `VL_WIDTH`: vl width; vl is `VL_WIDTH+1` bits wide.
  - `offset_t`: element offset type.

Ports:
- `CLK` in, 1: clock; all state updates on the rising edge.
- `nRST` in, 1: asynchronous reset, active-low.
- `start` in, 1: request to sequence a new operation; accepted only when `ready` is 1.
- `ready` out, 1: sequencer idle and able to accept `start`.
- `vl_in` in, `VL_WIDTH+1`: number of active elements for the operation.
- `vs1_in`, `vs2_in`, `vs3_in` in, 5 each: source register numbers.
- `stall` in, 1: downstream not accepting the current beat.
- `flush` in, 1: abort the current operation.
- `vs1`, `vs2`, `vs3` out, 5 each: latched register selects to the register file.
- `vs1_offset`, `vs2_offset`, `vs3_offset` out, `[LANES-1:0]` of `offset_t`: per-lane element index; identical across the three sources.
- `lane_valid` out, `LANES`: bit i set when lane i's element index is below vl.
- `beat_valid` out, 1: outputs describe a live beat.
- `last` out, 1: current beat is the final beat.
- `done` out, 1: one-cycle pulse when an operation completes normally.

## Operation
- States: `IDLE`, `RUN`. `ready = (state == IDLE)`.
- Reset (`nRST` low, asynchronous):
  - state goes to `IDLE`.
  - Every output is 0 except `ready`, which is 1.
  - Internal `base`, `vl_q` and register latches clear to 0.
- `IDLE` with `start`:
  - Latch `vs1_in`, `vs2_in`, `vs3_in` and `vl_in`; set `base` to 0.
  - If `vl_in` is not 0, go to `RUN`.
  - If `vl_in` is 0, stay in `IDLE` and pulse `done` the next cycle; no beat is issued.
- `RUN` outputs:
  - `beat_valid` is 1.
  - `vsX_offset[i] = base + i`, zero-extended or truncated to `offset_t`.
  - `lane_valid[i] = (base + i < vl_q)`.
  - `last = (base + LANES >= vl_q)`.
- Beat accepted means `beat_valid & ~stall`.
  - On accept with `last` 0: `base` increases by `LANES`.
  - On accept with `last` 1: go to `IDLE` and set `done` to 1 for one cycle.
- On stall, every output holds its value unchanged.
- `flush` (highest priority after reset):
  - Forces `IDLE` on the next edge; no `done` pulse.
  - Overrides a simultaneous accept of the last beat; `done` is suppressed.
  - Overrides a simultaneous `start` in `IDLE`: the start is dropped.
- `start` while in `RUN` is ignored; the latched values do not change.
- Arithmetic:
  - `base` and its comparisons are computed at `VL_WIDTH+2` bits, so `base + LANES` cannot wrap.
  - A full-scale `vl` produces the correct final partial mask.
- The register selects and `vl_q` stay stable for the whole operation. They keep their last values in `IDLE`, but `beat_valid` is 0 there.

## Timing
- `start` accepted at edge N: the first beat is visible in the cycle after edge N. No combinational path exists from `start` to the outputs.
- Beat count is `ceil(vl / LANES)`. With no stalls, throughput is `LANES` elements per cycle.
- `done` is registered. It is high exactly in the cycle after the edge that accepted the last beat, and `ready` is 1 in that same cycle.
- A new `start` may be accepted in the `done` cycle (back-to-back). Its first beat follows one cycle later, leaving a one-cycle bubble.
- Operation latency from `start` to `done` is `ceil(vl/LANES) + 1` cycles plus stall cycles. With `vl = 0` it is 1 cycle.
- `stall` and `flush` are sampled at the edge; their effect appears in the following cycle.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for a clock edge.

## Test plan
- LANES=2, vl=5, vs1=3, vs2=7, vs3=9, no stall:
  - Three beats with offsets (0,1), (2,3), (4,5).
  - `lane_valid` is 11, 11, 01.
  - `last` is set on beat 3 only.
  - `done` pulses one cycle later; `vs1/vs2/vs3` read 3/7/9 throughout.
- Same operation with `stall` held for 2 cycles on beat 2: beat 2 outputs hold for 3 cycles, and `done` arrives 2 cycles later than the no-stall case.
- vl=0 start: no `beat_valid`, `done` pulses in the next cycle, `ready` stays 1.
- vl=8, LANES=2, `flush` asserted during beat 2: `IDLE` next cycle, no `done`. A following start with vl=1 yields one beat with offsets (0,1), mask 01 and `last` 1.
- `start` with vl=2 issued during `RUN` is ignored. A `start` in the `done` cycle is accepted, giving back-to-back operations with a 1-cycle bubble.
- `nRST` pulsed low mid-beat: all outputs 0 and `ready` 1 immediately; normal operation resumes on the next `start`.
